regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 101 ++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb: read ports, issue handshake,
// writeback port and hazard/error status.
interface regfile_sb_if #(
  parameter int WIDTH = 64
);
  logic [4:0]       ra1;
  logic [4:0]       ra2;
  logic             use1;
  logic             use2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             issue_valid;
  logic [4:0]       issue_dst;
  logic             issue_ready;
  logic             wvalid;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;
  logic             stall;
  logic             err;

  modport master (
    output ra1, ra2, use1, use2, issue_valid, issue_dst, wvalid, wa, wd,
    input  rd1, rd2, issue_ready, stall, err
  );

  modport slave (
    input  ra1, ra2, use1, use2, issue_valid, issue_dst, wvalid, wa, wd,
    output rd1, rd2, issue_ready, stall, err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with write-first bypass and a per-register in-flight
// counter scoreboard that raises RAW stalls and gates instruction issue.
module regfile_sb #(
  parameter int NREG  = 32,
  parameter int WIDTH = 64,
  parameter int CNT_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_ONE = 1;

  word_t rf_word [NREG];
  cnt_t  rf_cnt  [NREG];
  logic  err_reg;
  logic  wr_en;
  logic  issue_fire;
  logic  issue_ready;
  logic  h1;
  logic  h2;
  logic  stall;
  word_t rd1;
  word_t rd2;

  assign wr_en      = bus.wvalid && (bus.wa != '0);
  assign issue_fire = bus.issue_valid && issue_ready;

  // x0 is hardwired: no storage, never in flight.
  assign rf_word[0] = '0;
  assign rf_cnt[0]  = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      word_t data_reg;
      cnt_t  cnt_reg;
      logic  inc;
      logic  dec;

      assign inc = issue_fire && (bus.issue_dst == 5'(gi));
      assign dec = wr_en && (bus.wa == 5'(gi));

      // Issue and retire on the same register cancel; a retire at zero is
      // absorbed here and flagged through err_reg.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (dec)
            data_reg <= bus.wd;
          if (inc && !dec)
            cnt_reg <= cnt_reg + CNT_ONE;
          else if (dec && !inc && (cnt_reg != '0))
            cnt_reg <= cnt_reg - CNT_ONE;
        end
      end

      assign rf_word[gi] = data_reg;
      assign rf_cnt[gi]  = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      err_reg <= 1'b0;
    else if (wr_en && (rf_cnt[bus.wa] == '0))
      err_reg <= 1'b1;
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (bus.ra1 != '0)
      rd1 = (bus.wvalid && (bus.wa == bus.ra1)) ? bus.wd : rf_word[bus.ra1];
    if (bus.ra2 != '0)
      rd2 = (bus.wvalid && (bus.wa == bus.ra2)) ? bus.wd : rf_word[bus.ra2];
  end

  // A retire of the last outstanding writer releases the hazard this cycle.
  always_comb begin
    h1 = bus.use1 && (bus.ra1 != '0) && (rf_cnt[bus.ra1] != '0) &&
         !(bus.wvalid && (bus.wa == bus.ra1) && (rf_cnt[bus.ra1] == CNT_ONE));
    h2 = bus.use2 && (bus.ra2 != '0) && (rf_cnt[bus.ra2] != '0) &&
         !(bus.wvalid && (bus.wa == bus.ra2) && (rf_cnt[bus.ra2] == CNT_ONE));
    stall       = h1 || h2;
    issue_ready = !stall &&
                  ((bus.issue_dst == '0) || (rf_cnt[bus.issue_dst] != CNT_MAX));
  end

  assign bus.rd1         = rd1;
  assign bus.rd2         = rd2;
  assign bus.stall       = stall;
  assign bus.issue_ready = issue_ready;
  assign bus.err         = err_reg;
endmodule
